// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and encodings for the register-file write path
package regfile_pkg;

   localparam int REG_DW = 32;
   localparam int REG_AW = 5;
   localparam int REG_N  = 32;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_ARB   = 1'b1
   } state_t;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_LD  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; priority flips only when a grant is taken
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_valid,
   input  logic       i_upd,
   output logic [1:0] o_grant
);
   import regfile_pkg::*;

   logic r_rr_ptr;

   always_comb begin
      o_grant = i_valid;
      if (i_valid == 2'b11) begin
         o_grant = (r_rr_ptr == REQ_LD) ? 2'b10 : 2'b01;
      end
   end

   // The requester just served loses priority to the other one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= REQ_ALU;
      end else if (i_upd) begin
         r_rr_ptr <= ~o_grant[1];
      end
   end

endmodule

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - write-port controller for the 32x32 register file
// Arbitrates ALU/load writebacks onto the single write port and runs zero-clear passes.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int DW           = REG_DW,
   parameter int AW           = REG_AW,
   parameter int NREG         = REG_N,
   parameter bit CLEAR_ON_RST = 1'b1,
   parameter bit ZERO_R0      = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [AW-1:0] req0_sel,
   input  logic [DW-1:0] req0_data,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [AW-1:0] req1_sel,
   input  logic [DW-1:0] req1_data,
   input  logic          clr_start,
   output logic          busy,
   output logic          WR,
   output logic [AW-1:0] sel_i1,
   output logic [DW-1:0] Ip1,
   output logic          EN
);

   localparam state_t      ST_RST   = CLEAR_ON_RST ? ST_CLEAR : ST_ARB;
   localparam logic [AW:0] CNT_LAST = (AW+1)'(NREG - 1);
   localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

   state_t        r_state;
   logic [AW:0]   r_clr_cnt;
   logic          r_wr;
   logic [AW-1:0] r_sel;
   logic [DW-1:0] r_ip1;
   logic          r_en;

   state_t        w_nxt_state;
   logic [AW:0]   w_nxt_cnt;
   logic          w_nxt_wr;
   logic [AW-1:0] w_nxt_sel;
   logic [DW-1:0] w_nxt_ip1;
   logic [1:0]    w_grant;
   logic          w_arb_ok;
   logic          w_accept;
   logic [AW-1:0] w_acc_sel;
   logic [DW-1:0] w_acc_data;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst_n   (rst),
      .i_valid ({req1_valid, req0_valid}),
      .i_upd   (w_accept),
      .o_grant (w_grant)
   );

   // Ready is held low during reset as well, whatever the reset state is.
   assign w_arb_ok   = rst && (r_state == ST_ARB) && !clr_start;
   assign req0_ready = w_grant[0] && w_arb_ok;
   assign req1_ready = w_grant[1] && w_arb_ok;
   assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign w_acc_sel  = w_grant[1] ? req1_sel  : req0_sel;
   assign w_acc_data = w_grant[1] ? req1_data : req0_data;
   assign busy       = rst && (r_state == ST_CLEAR);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_clr_cnt;
      w_nxt_wr    = 1'b0;
      w_nxt_sel   = r_sel;
      w_nxt_ip1   = r_ip1;
      case (r_state)
         ST_CLEAR: begin
            w_nxt_wr  = 1'b1;
            w_nxt_sel = r_clr_cnt[AW-1:0];
            w_nxt_ip1 = '0;
            if (r_clr_cnt == CNT_LAST) begin
               w_nxt_state = ST_ARB;
               w_nxt_cnt   = '0;
            end else begin
               w_nxt_cnt = r_clr_cnt + CNT_ONE;
            end
         end
         ST_ARB: begin
            if (clr_start) begin
               w_nxt_state = ST_CLEAR;
               w_nxt_cnt   = '0;
            end else if (w_accept && !(ZERO_R0 && (w_acc_sel == '0))) begin
               w_nxt_wr  = 1'b1;
               w_nxt_sel = w_acc_sel;
               w_nxt_ip1 = w_acc_data;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_RST;
         r_clr_cnt <= '0;
         r_wr      <= 1'b0;
         r_sel     <= '0;
         r_ip1     <= '0;
         r_en      <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_clr_cnt <= w_nxt_cnt;
         r_wr      <= w_nxt_wr;
         r_sel     <= w_nxt_sel;
         r_ip1     <= w_nxt_ip1;
         r_en      <= 1'b1;
      end
   end

   assign WR     = r_wr;
   assign sel_i1 = r_sel;
   assign Ip1    = r_ip1;
   assign EN     = r_en;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb/tb_regfile_wr_arb.sv - self-checking bench for regfile_wr_arb
module tb_regfile_wr_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_sel, req1_sel, sel_i1;
   logic [31:0] req0_data, req1_data, Ip1;
   logic        clr_start, busy, WR, EN;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: expected register-file port and who was served last.
   bit m_clear, m_wr, m_en, m_known;
   int m_idx, m_last, m_sel, m_served;
   logic [31:0] m_ip1;

   typedef struct {
      logic v0; logic [4:0] s0; logic [31:0] d0;
      logic v1; logic [4:0] s1; logic [31:0] d1;
      logic r0; logic r1; logic wr; logic chk_d;
      logic [4:0] sel; logic [31:0] ip;
   } vec_t;
   vec_t tbl [9];

   regfile_wr_arb dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_data(req1_data),
      .clr_start(clr_start), .busy(busy), .WR(WR), .sel_i1(sel_i1), .Ip1(Ip1), .EN(EN)
   );

   always #10 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_clear = 1'b1; m_idx = 0; m_last = 1; m_wr = 1'b0; m_en = 1'b0;
      m_sel = 0; m_ip1 = '0; m_known = 1'b1; m_served = -1;
   endtask

   // One clock: check handshake against the model, advance it, check the write port.
   task automatic tick();
      int k;
      int s;
      logic [31:0] d;
      #1;
      k = -1;
      if (!m_clear && !clr_start) begin
         if (req0_valid && req1_valid) k = (m_last == 0) ? 1 : 0;
         else if (req0_valid)          k = 0;
         else if (req1_valid)          k = 1;
      end
      chk("req0_ready", req0_ready, k == 0);
      chk("req1_ready", req1_ready, k == 1);
      chk("busy", busy, m_clear);
      m_served = k;
      m_en = 1'b1;
      if (m_clear) begin
         m_wr = 1'b1; m_sel = m_idx; m_ip1 = '0; m_known = 1'b1;
         m_idx++;
         if (m_idx == 32) begin m_clear = 1'b0; m_idx = 0; end
      end else if (clr_start) begin
         m_clear = 1'b1; m_idx = 0; m_wr = 1'b0;
      end else if (k >= 0) begin
         m_last = k;
         s = (k == 1) ? int'(req1_sel) : int'(req0_sel);
         d = (k == 1) ? req1_data : req0_data;
         if (s == 0) begin
            m_wr = 1'b0; m_known = 1'b0;
         end else begin
            m_wr = 1'b1; m_sel = s; m_ip1 = d; m_known = 1'b1;
         end
      end else begin
         m_wr = 1'b0;
      end
      @(posedge clk); #1;
      chk("WR", WR, m_wr);
      chk("EN", EN, m_en);
      if (m_known) begin
         chk("sel_i1", sel_i1, m_sel);
         chk("Ip1", Ip1, m_ip1);
      end
   endtask

   initial begin
      bit p0, p1;
      tbl[0] = '{1, 2, 14, 0, 0, 0,  1, 0, 1, 1, 2, 14};
      tbl[1] = '{0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 2, 14};
      tbl[2] = '{0, 0, 0,  1, 0, 5,  0, 1, 0, 0, 0, 0};
      tbl[3] = '{0, 0, 0,  1, 6, 0,  0, 1, 1, 1, 6, 0};
      tbl[4] = '{1, 4, 7,  1, 10, 9, 1, 0, 1, 1, 4, 7};
      tbl[5] = '{1, 4, 7,  1, 10, 9, 0, 1, 1, 1, 10, 9};
      tbl[6] = '{1, 4, 7,  1, 10, 9, 1, 0, 1, 1, 4, 7};
      tbl[7] = '{1, 4, 7,  1, 10, 9, 0, 1, 1, 1, 10, 9};
      tbl[8] = '{0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 10, 9};

      // Reset state, with a requester already waiting.
      rst = 1'b0; clr_start = 1'b0;
      req0_valid = 1'b0; req0_sel = '0; req0_data = '0;
      req1_valid = 1'b1; req1_sel = 5'd3; req1_data = 32'h55;
      model_reset();
      #1;
      chk("rst_WR", WR, 0); chk("rst_sel", sel_i1, 0); chk("rst_Ip1", Ip1, 0);
      chk("rst_EN", EN, 0); chk("rst_busy", busy, 0); chk("rst_ready1", req1_ready, 0);
      #2 rst = 1'b1;

      // Power-up clear pass, then the waiting requester and an idle cycle.
      for (int i = 0; i < 32; i++) tick();
      tick();
      chk("post_clear_wr_sel", sel_i1, 3);
      req1_valid = 1'b0;
      tick();
      chk("post_clear_idle_WR", WR, 0);

      // Table-driven single writes, r0 drop and alternating arbitration.
      for (int i = 0; i < 9; i++) begin
         req0_valid = tbl[i].v0; req0_sel = tbl[i].s0; req0_data = tbl[i].d0;
         req1_valid = tbl[i].v1; req1_sel = tbl[i].s1; req1_data = tbl[i].d1;
         #1;
         chk($sformatf("tbl%0d_r0", i), req0_ready, tbl[i].r0);
         chk($sformatf("tbl%0d_r1", i), req1_ready, tbl[i].r1);
         tick();
         chk($sformatf("tbl%0d_wr", i), WR, tbl[i].wr);
         if (tbl[i].chk_d) begin
            chk($sformatf("tbl%0d_sel", i), sel_i1, tbl[i].sel);
            chk($sformatf("tbl%0d_ip", i), Ip1, tbl[i].ip);
         end
      end

      // clr_start while a request is pending: request waits out the clear.
      req0_valid = 1'b1; req0_sel = 5'd8; req0_data = 32'd3; clr_start = 1'b1;
      #1 chk("clr_blocks_ready", req0_ready, 0);
      tick();
      chk("clr_edge_WR", WR, 0);
      clr_start = 1'b0;
      for (int i = 0; i < 32; i++) tick();
      tick();
      chk("after_clr_WR", WR, 1); chk("after_clr_sel", sel_i1, 8); chk("after_clr_ip", Ip1, 3);
      req0_valid = 1'b0;

      // Asynchronous reset in the middle of a clear pass.
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("mid_clear_sel", sel_i1, 9);
      #5 rst = 1'b0;
      #1;
      chk("async_WR", WR, 0); chk("async_sel", sel_i1, 0); chk("async_Ip1", Ip1, 0);
      chk("async_EN", EN, 0); chk("async_busy", busy, 0);
      model_reset();
      #3 rst = 1'b1;
      tick();
      chk("restart_sel0", sel_i1, 0); chk("restart_WR", WR, 1);
      for (int i = 0; i < 31; i++) tick();

      // Random traffic with stable-until-ready requesters and occasional clears.
      p0 = 1'b0; p1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && ($urandom_range(0, 1) == 1)) begin
            p0 = 1'b1; req0_sel = 5'($urandom_range(0, 31)); req0_data = $urandom;
         end
         if (!p1 && ($urandom_range(0, 1) == 1)) begin
            p1 = 1'b1; req1_sel = 5'($urandom_range(0, 31)); req1_data = $urandom;
         end
         req0_valid = p0; req1_valid = p1;
         clr_start = ($urandom_range(0, 39) == 0);
         tick();
         if (m_served == 0) p0 = 1'b0;
         if (m_served == 1) p1 = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Write-port controller for the 32x32 register file (regFile).
- Shares the register file's single write port (WR, sel_i1, Ip1) between two writeback requesters (req0 = ALU, req1 = load unit) using valid/ready handshakes and round-robin arbitration.
- Sequences a clear pass that writes zero to every register after reset or on command.
- Drives the register file's EN.
- Read ports (sel_o1/sel_o2/RD) are not touched by this block.

Parameters:
- DW, 32, data width of Ip1 and the request data.
- AW, 5, register select width.
- NREG, 32, number of registers cleared; NREG <= 2**AW.
- CLEAR_ON_RST, 1, 1 = enter CLEAR after reset; 0 = enter ARB directly.
- ZERO_R0, 1, 1 = writes to register 0 are accepted and discarded.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_sel  in  AW  destination register for requester 0.
- req0_data  in  DW  write data for requester 0.
- req1_valid, req1_ready, req1_sel, req1_data: same as req0, for requester 1.
- clr_start  in  1  pulse; launches a clear pass.
- busy  out  1  high while in CLEAR.
- WR  out  1  register-file write strobe (registered).
- sel_i1  out  AW  register-file write select (registered).
- Ip1  out  DW  register-file write data (registered).
- EN  out  1  register-file enable (registered).

Behaviour:
- Reset (rst=0), asynchronous, all outputs forced immediately:
  - WR=0, sel_i1=0, Ip1=0, EN=0, busy=0, rr_ptr=0, clr_cnt=0.
  - State = CLEAR if CLEAR_ON_RST, else ARB.
  - req*_ready=0 while rst=0.
- EN goes to 1 on the first rising edge after rst deasserts and stays 1.
- States: CLEAR, ARB.
- CLEAR:
  - busy=1 combinationally; req0_ready=req1_ready=0; clr_start ignored.
  - Each edge: WR<=1, sel_i1<=clr_cnt, Ip1<=0, clr_cnt<=clr_cnt+1.
  - The edge that issues clr_cnt=NREG-1 moves the state to ARB and resets clr_cnt to 0.
  - A full pass is exactly NREG cycles of WR=1.
- ARB, grant logic (combinational):
  - Only reqK_valid high: grant K.
  - Both valid: grant rr_ptr.
  - reqK_ready = grant_K && !clr_start.
- ARB, on an edge with reqK_valid && reqK_ready:
  - WR<=1, sel_i1<=reqK_sel, Ip1<=reqK_data, rr_ptr<=~K.
  - Latency: accept edge to WR high is 1 cycle.
  - Back-to-back accepts produce WR high on consecutive cycles; throughput is 1 write per cycle.
- ARB, no accept on an edge: WR<=0; sel_i1 and Ip1 hold their previous values.
- ZERO_R0=1 and accepted sel==0: ready and rr_ptr update as normal, but WR<=0. The write is silently dropped.
- clr_start=1 in ARB:
  - No grant that cycle; next edge enters CLEAR with clr_cnt=0 and WR<=0 on that edge.
  - Pending requests wait; requesters must hold valid, sel and data stable until ready.
- Fairness: with both requesters continuously valid, grants strictly alternate. A waiting requester is served within 2 grants.
- rr_ptr updates only on an accept; idle cycles keep priority unchanged.
- Reset asserted mid-CLEAR or mid-ARB: immediate return to reset values. A clear pass always restarts from register 0.
- clr_cnt is AW+1 bits wide so NREG=2**AW compares without wrap.

Decomposition:
- Shared package regfile_pkg holds:
  - Constants REG_DW=32, REG_AW=5, REG_N=32.
  - State encoding ST_CLEAR=1'b0, ST_ARB=1'b1.
  - Requester IDs REQ_ALU=0, REQ_LD=1.
- One natural sub-module: rr_arb2. It is a 2-way round-robin grant with an rr_ptr register and an update-on-accept input, reusable for read-port sharing later.
- FSM, clear counter and output registers stay in regfile_wr_arb.

Test Plan:
1. Release rst at 3 ns, CLEAR_ON_RST=1, 20 ns clock -> 32 consecutive cycles with WR=1, sel_i1=0..31, Ip1=0; busy=1 and ready=0 throughout; then busy=0, WR=0, EN=1.
2. After clear, req0_valid=1, sel=2, data=14 for one cycle -> req0_ready=1 that cycle; next cycle WR=1, sel_i1=2, Ip1=14; following cycle WR=0.
3. req0 (sel 4, data 7) and req1 (sel 10, data 9) both held valid for 4 cycles from rr_ptr=0 -> accepts in order 0,1,0,1; WR high 4 consecutive cycles; sel_i1 = 4,10,4,10.
4. ZERO_R0=1, req1_valid with sel=0, data=5 -> req1_ready=1, WR stays 0, rr_ptr becomes 0; a subsequent req1 (sel 6, data 0) is written normally.
5. clr_start pulsed while req0 valid (sel 8, data 3) -> req0_ready=0, busy=1 next cycle, 32-cycle clear runs, then req0 is accepted and written to sel_i1=8, Ip1=3.
6. rst driven low while clr_cnt=10 -> WR, sel_i1, Ip1, EN go to 0 without waiting for a clock edge; after release, clear restarts at sel_i1=0.
